// File: rtl/ntt_intt_op_scheduler.sv
// Round-robin scheduler sharing one NTT/INTT core between NUM_REQ requesters.
// Optional WAIT-state watchdog is compiled in with NTT_SCHED_TIMEOUT_EN.
module ntt_intt_op_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int OWN_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        cmd_valid_i,
  output logic [NUM_REQ-1:0]        cmd_ready_o,
  input  logic [2*NUM_REQ-1:0]      cmd_op_i,
  input  logic [ADDR_W*NUM_REQ-1:0] cmd_base_i,
  output logic                      core_start_o,
  output logic [1:0]                core_op_o,
  output logic [ADDR_W-1:0]         core_base_o,
  input  logic                      core_done_i,
  output logic [NUM_REQ-1:0]        cmpl_valid_o,
  output logic                      cmpl_err_o,
  output logic                      busy_o,
  output logic [OWN_W-1:0]          owner_o,
  input  logic                      intr_en_i,
  input  logic                      intr_clr_i,
  output logic                      intr_o
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_CMPL} state_t;

  localparam logic [1:0] OP_RSVD = 2'b11;

  state_t              state_q, state_d;
  logic [OWN_W-1:0]    rr_q, owner_q, win, idx;
  logic                win_vld, accept, tmo_hit, err_q, intr_q;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   base_q;
  logic [1:0]          op_arr   [NUM_REQ];
  logic [ADDR_W-1:0]   base_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g]   = cmd_op_i[2*g +: 2];
    assign base_arr[g] = cmd_base_i[ADDR_W*g +: ADDR_W];
  end

  // Search starts at rr and wraps, so the last owner has lowest priority next.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = OWN_W'((int'(rr_q) + k) % NUM_REQ);
      if (!win_vld && cmd_valid_i[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign accept = (state_q == S_IDLE) && win_vld;

`ifdef NTT_SCHED_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;

  // Counter reads n-1 in the n-th WAIT cycle; the TIMEOUT_CYCLES-th cycle gives up.
  assign tmo_hit = (state_q == S_WAIT) && (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   tmo_cnt_q <= '0;
    else if (state_q == S_START) tmo_cnt_q <= '0;
    else if (state_q == S_WAIT)  tmo_cnt_q <= tmo_cnt_q + 32'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (win_vld) state_d = (op_arr[win] == OP_RSVD) ? S_CMPL : S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (core_done_i || tmo_hit) state_d = S_CMPL;
      S_CMPL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      op_q    <= '0;
      base_q  <= '0;
      err_q   <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= win;
        op_q    <= op_arr[win];
        base_q  <= base_arr[win];
        err_q   <= (op_arr[win] == OP_RSVD);
      end
      if (state_q == S_WAIT) begin
        if (core_done_i)  err_q <= 1'b0;
        else if (tmo_hit) err_q <= 1'b1;
      end
      if (state_q == S_CMPL) rr_q <= OWN_W'((int'(owner_q) + 1) % NUM_REQ);
      // Set has priority over clear so a completion is never lost.
      if ((state_q == S_CMPL) && intr_en_i) intr_q <= 1'b1;
      else if (intr_clr_i)                  intr_q <= 1'b0;
    end
  end

  // Ready is held low while reset is asserted so no handshake can occur during it.
  always_comb begin
    cmd_ready_o = '0;
    if (accept && !rst_i) cmd_ready_o[win] = 1'b1;
  end

  always_comb begin
    cmpl_valid_o = '0;
    if (state_q == S_CMPL) cmpl_valid_o[owner_q] = 1'b1;
  end

  assign cmpl_err_o   = (state_q == S_CMPL) && err_q;
  assign core_start_o = (state_q == S_START);
  assign core_op_o    = op_q;
  assign core_base_o  = base_q;
  assign busy_o       = (state_q != S_IDLE);
  assign owner_o      = owner_q;
  assign intr_o       = intr_q;

endmodule
